// File: rtl/mem_stage.sv
// Memory stage of the RV32I pipeline: word-wide data-memory requests, stall/flush/redirect,
// forwarding to execute and the writeback register. Optional counters under MEM_PERF_EN.
module mem_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PERF_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            regwrite,
  input  logic            loadF,
  input  logic            storeF,
  input  logic            jalF,
  input  logic            jalrF,
  input  logic [XLEN-1:0] target,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] store_data,
  input  logic            branch_cond,
  input  logic [4:0]      regDF,
  output logic            stall,
  output logic            branch_flush,
  output logic            jal_flush,
  output logic [XLEN-1:0] redirect_pc,
  output logic [4:0]      regD_mem,
  output logic [XLEN-1:0] regD_val_mem,
  output logic            regwrite_mem,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic            dmem_req_we,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic [XLEN-1:0] dmem_req_wdata,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_regwrite,
  output logic [4:0]      wb_regD,
  output logic [XLEN-1:0] wb_val
`ifdef MEM_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_stall_cycles,
  output logic [PERF_W-1:0] perf_loads,
  output logic [PERF_W-1:0] perf_stores
`endif
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] REQ_WAIT  = 2'd1;
  localparam logic [1:0] RESP_WAIT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            wb_regwrite_q, wb_regwrite_d;
  logic [4:0]      wb_regD_q, wb_regD_d;
  logic [XLEN-1:0] wb_val_q, wb_val_d;

  logic mem_op, req_fire, load_completing, rd_nonzero;

  assign mem_op          = loadF | storeF;
  assign rd_nonzero      = (regDF != 5'd0);
  assign load_completing = (state_q == RESP_WAIT) && dmem_rvalid && !rst;
  assign req_fire        = dmem_req_valid && dmem_req_ready;

  // Request fields come straight from the held upstream inputs, so they stay stable in REQ_WAIT.
  assign dmem_req_valid = !rst && (((state_q == IDLE) && mem_op) || (state_q == REQ_WAIT));
  assign dmem_req_we    = storeF;
  assign dmem_req_addr  = {result[XLEN-1:2], 2'b00};
  assign dmem_req_wdata = storeF ? store_data : '0;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (!dmem_req_ready) begin
            state_d = REQ_WAIT;
            stall   = 1'b1;
          end else if (loadF) begin
            state_d = RESP_WAIT;
            stall   = 1'b1;
          end
        end
      end
      REQ_WAIT: begin
        stall = 1'b1;
        if (dmem_req_ready) begin
          if (storeF) begin
            state_d = IDLE;
            stall   = 1'b0;
          end else begin
            state_d = RESP_WAIT;
          end
        end
      end
      RESP_WAIT: begin
        stall = 1'b1;
        if (dmem_rvalid) begin
          state_d = IDLE;
          stall   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      state_d = IDLE;
      stall   = 1'b0;
    end
  end

  assign branch_flush = branch_cond;
  assign jal_flush    = jalF | jalrF;
  assign redirect_pc  = (branch_flush || jal_flush) ? target : '0;

  // A load not yet completing has no value to forward.
  assign regD_mem     = regDF;
  assign regD_val_mem = load_completing ? dmem_rdata : result;
  assign regwrite_mem = regwrite && rd_nonzero && !(loadF && !load_completing);

  always_comb begin
    wb_regwrite_d = 1'b0;
    wb_regD_d     = wb_regD_q;
    wb_val_d      = wb_val_q;
    if (!stall) begin
      wb_regwrite_d = regwrite && rd_nonzero;
      wb_regD_d     = regDF;
      wb_val_d      = loadF ? dmem_rdata : result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wb_regwrite_q <= 1'b0;
      wb_regD_q     <= 5'd0;
      wb_val_q      <= '0;
    end else begin
      state_q       <= state_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_regD_q     <= wb_regD_d;
      wb_val_q      <= wb_val_d;
    end
  end

  assign wb_regwrite = wb_regwrite_q;
  assign wb_regD     = wb_regD_q;
  assign wb_val      = wb_val_q;

`ifdef MEM_PERF_EN
  logic [PERF_W-1:0] perf_stall_q, perf_stall_d;
  logic [PERF_W-1:0] perf_loads_q, perf_loads_d;
  logic [PERF_W-1:0] perf_stores_q, perf_stores_d;

  // Saturating: counters stick at all-ones rather than wrapping.
  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_loads_d  = perf_loads_q;
    perf_stores_d = perf_stores_q;
    if (stall && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 1'b1;
    if (load_completing && (perf_loads_q != '1))
      perf_loads_d = perf_loads_q + 1'b1;
    if (req_fire && dmem_req_we && (perf_stores_q != '1))
      perf_stores_d = perf_stores_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q  <= '0;
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_loads_q  <= perf_loads_d;
      perf_stores_q <= perf_stores_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_loads        = perf_loads_q;
  assign perf_stores       = perf_stores_q;
`else
  logic        unused_bits;
  logic [31:0] unused_perf_w;
  assign unused_bits   = ^{result[1:0], req_fire};
  assign unused_perf_w = PERF_W;
`endif

endmodule
